// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable RS-232 receiver with parity, framing and overrun
// detection; received words leave through a valid/ready output register.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   RXD_i                serial line, idle high, asynchronous to clk_i
//   data_o, valid_o      received word and its valid flag
//   ready_i              consumer takes the word when valid_o & ready_i
//   parity_err_o         parity mismatch on the word in data_o
//   frame_err_o          a stop bit sampled low for the word in data_o
//   overrun_o            one-cycle pulse when a completed word is dropped
//   busy_o               a frame is being received
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 RXD_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA =
    BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP =
    BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   fill_q, fill_d;
  logic                   rxs_prev_q, rxs_prev_d;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;

  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_o_q, perr_o_d;
  logic                   ferr_o_q, ferr_o_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;

  logic rxs;
  logic armed;
  logic fall;

  assign rxs = sync_q[SYNC_STAGES-1];

  // The sync chain is preset to 1 by reset, so an edge only counts once
  // rxs_prev holds a sample that really came from the line.
  assign armed = fill_q[SYNC_STAGES];
  assign fall  = armed & rxs_prev_q & ~rxs;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], RXD_i};
    fill_d     = {fill_q[SYNC_STAGES-1:0], 1'b1};
    rxs_prev_d = rxs;

    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_acc_d = par_acc_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = S_START;
          bit_d     = '0;
          par_acc_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rxs;
          bit_d     = bit_q + BW'(1);
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (PARITY == 1)
            perr_d = ~(par_acc_q ^ rxs);
          else
            perr_d = par_acc_q ^ rxs;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          bit_d = bit_q + BW'(1);
          if (!rxs)
            ferr_d = 1'b1;
          // Leave at the last mid-stop sample so a start bit that
          // follows straight after is still seen.
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    data_d   = data_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    ovr_d    = 1'b0;

    if (done_q) begin
      if (!valid_q || ready_i) begin
        data_d   = shift_q;
        perr_o_d = perr_q;
        ferr_o_d = ferr_q;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q     <= '1;
      fill_q     <= '0;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_o_q   <= 1'b0;
      ferr_o_q   <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      fill_q     <= fill_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_o_q   <= perr_o_d;
      ferr_o_q   <= ferr_o_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_o_q;
  assign frame_err_o  = ferr_o_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule
